// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU control unit: FSM states, instruction classes,
// branch condition codes, ALU op constants and instruction field positions.
package cpu_pkg;

   typedef enum logic [3:0] {
      ST_RST,
      ST_FETCH,
      ST_DECODE,
      ST_ALU,
      ST_LOAD,
      ST_STORE,
      ST_BRANCH,
      ST_JUMP,
      ST_HALT
   } state_t;

   typedef enum logic [2:0] {
      CLS_ALU    = 3'b000,
      CLS_LOAD   = 3'b001,
      CLS_STORE  = 3'b010,
      CLS_BRANCH = 3'b011,
      CLS_JUMP   = 3'b100,
      CLS_ILL5   = 3'b101,
      CLS_ILL6   = 3'b110,
      CLS_HALT   = 3'b111
   } class_t;

   typedef enum logic [2:0] {
      COND_ALWAYS = 3'b000,
      COND_Z      = 3'b001,
      COND_NZ     = 3'b010,
      COND_C      = 3'b011,
      COND_NC     = 3'b100,
      COND_N      = 3'b101,
      COND_NN     = 3'b110,
      COND_NEVER  = 3'b111
   } cond_t;

   localparam logic [3:0] ALU_PASS_S = 4'b0000;

   localparam int CLS_MSB  = 15;
   localparam int CLS_LSB  = 13;
   localparam int OP_MSB   = 12;
   localparam int OP_LSB   = 9;
   localparam int W_MSB    = 8;
   localparam int W_LSB    = 6;
   localparam int R_MSB    = 5;
   localparam int R_LSB    = 3;
   localparam int S_MSB    = 2;
   localparam int S_LSB    = 0;
   localparam int COND_MSB = 10;
   localparam int COND_LSB = 8;

   // Status register layout is {C, N, Z}.
   localparam int STAT_C = 2;
   localparam int STAT_N = 1;
   localparam int STAT_Z = 0;

endpackage

// File: rtl/cu_cond_eval.sv
// Branch condition evaluator: decides whether a branch is taken from the
// condition code and the latched {C, N, Z} status.
module cu_cond_eval
   import cpu_pkg::*;
(
   input  logic [2:0] i_cond,
   input  logic [2:0] i_status,
   output logic       o_taken
);

   logic w_c;
   logic w_n;
   logic w_z;

   assign w_c = i_status[STAT_C];
   assign w_n = i_status[STAT_N];
   assign w_z = i_status[STAT_Z];

   always_comb begin
      o_taken = 1'b0;
      case (i_cond)
         COND_ALWAYS: o_taken = 1'b1;
         COND_Z:      o_taken = w_z;
         COND_NZ:     o_taken = ~w_z;
         COND_C:      o_taken = w_c;
         COND_NC:     o_taken = ~w_c;
         COND_N:      o_taken = w_n;
         COND_NN:     o_taken = ~w_n;
         COND_NEVER:  o_taken = 1'b0;
         default:     o_taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit: sequences fetch, decode and execute for the CPU
// execution unit and drives all of its control inputs plus memory strobes.
module cpu_control_unit
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] IR_Out,
   input  logic        C,
   input  logic        N,
   input  logic        Z,
   output logic        W_En,
   output logic [2:0]  W_Adr,
   output logic [2:0]  R_Adr,
   output logic [2:0]  S_Adr,
   output logic        sel,
   output logic [3:0]  alu_op,
   output logic        adr_sel,
   output logic        pc_sel,
   output logic        ld_en,
   output logic        pc_inc,
   output logic        ir_en,
   output logic        mr_en,
   output logic        mw_en,
   output logic        halted,
   output logic        illegal
);

   state_t     r_state;
   state_t     w_next_state;
   logic [2:0] r_status;
   logic       r_illegal;
   logic       w_set_illegal;
   logic       w_taken;
   class_t     w_class;

   assign w_class = class_t'(IR_Out[CLS_MSB:CLS_LSB]);

   assign W_Adr   = IR_Out[W_MSB:W_LSB];
   assign R_Adr   = IR_Out[R_MSB:R_LSB];
   assign S_Adr   = IR_Out[S_MSB:S_LSB];
   assign illegal = r_illegal;

   cu_cond_eval u_cond_eval (
      .i_cond   (IR_Out[COND_MSB:COND_LSB]),
      .i_status (r_status),
      .o_taken  (w_taken)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; strobes are decoded from r_state, so the async reset
   // forces them low immediately without waiting for a clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_RST;
         r_status  <= 3'b000;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (r_state == ST_ALU) begin
            r_status <= {C, N, Z};
         end
         if (w_set_illegal) begin
            r_illegal <= 1'b1;
         end
      end
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      w_next_state  = r_state;
      w_set_illegal = 1'b0;
      W_En          = 1'b0;
      sel           = 1'b0;
      alu_op        = ALU_PASS_S;
      adr_sel       = 1'b0;
      pc_sel        = 1'b0;
      ld_en         = 1'b0;
      pc_inc        = 1'b0;
      ir_en         = 1'b0;
      mr_en         = 1'b0;
      mw_en         = 1'b0;
      halted        = 1'b0;

      case (r_state)
         ST_RST: begin
            w_next_state = ST_FETCH;
         end

         ST_FETCH: begin
            adr_sel      = 1'b0;
            mr_en        = 1'b1;
            ir_en        = 1'b1;
            pc_inc       = 1'b1;
            w_next_state = ST_DECODE;
         end

         ST_DECODE: begin
            case (w_class)
               CLS_ALU:    w_next_state = ST_ALU;
               CLS_LOAD:   w_next_state = ST_LOAD;
               CLS_STORE:  w_next_state = ST_STORE;
               CLS_BRANCH: w_next_state = ST_BRANCH;
               CLS_JUMP:   w_next_state = ST_JUMP;
               CLS_HALT:   w_next_state = ST_HALT;
               default: begin
                  w_set_illegal = 1'b1;
                  w_next_state  = ST_HALT;
               end
            endcase
         end

         ST_ALU: begin
            W_En         = 1'b1;
            sel          = 1'b0;
            alu_op       = IR_Out[OP_MSB:OP_LSB];
            w_next_state = ST_FETCH;
         end

         ST_LOAD: begin
            adr_sel      = 1'b1;
            mr_en        = 1'b1;
            sel          = 1'b1;
            alu_op       = ALU_PASS_S;
            W_En         = 1'b1;
            w_next_state = ST_FETCH;
         end

         ST_STORE: begin
            adr_sel      = 1'b1;
            sel          = 1'b0;
            alu_op       = ALU_PASS_S;
            mw_en        = 1'b1;
            w_next_state = ST_FETCH;
         end

         ST_BRANCH: begin
            // Taken and not-taken both return to FETCH, so latency is equal.
            if (w_taken) begin
               ld_en  = 1'b1;
               pc_sel = 1'b0;
            end
            w_next_state = ST_FETCH;
         end

         ST_JUMP: begin
            alu_op       = ALU_PASS_S;
            pc_sel       = 1'b1;
            ld_en        = 1'b1;
            w_next_state = ST_FETCH;
         end

         ST_HALT: begin
            halted       = 1'b1;
            w_next_state = ST_HALT;
         end

         default: begin
            w_next_state = ST_RST;
         end
      endcase
   end

endmodule
